wb_gpio_port: RTL and testbench
===============================

// Module: wb_gpio_port
// PURPOSE
//  Wishbone classic slave GPIO controller bridging the SoC Wishbone bus to the DE1 GPIO_1 header pins.
//  Provides per-pin direction, output data, synchronised input sampling and edge-triggered interrupts.
//  Sits downstream of the SoC bus interconnect and upstream of the board-level tristate pad logic.
// PARAMETERS
//  WIDTH      8   number of GPIO pins (1..32)
//  ADDR_WIDTH 5   byte-address bits decoded from wb_adr_i
// PORTS
//  wb_clk_i    in   1        Wishbone clock, the only clock
//  wb_rst_n_i  in   1        reset, asynchronous, active-low
//  wb_adr_i    in   ADDR_WIDTH byte address; word-aligned, [1:0] ignored
//  wb_dat_i    in   32       write data
//  wb_sel_i    in   4        byte lane enables
//  wb_we_i     in   1        write enable
//  wb_cyc_i    in   1        bus cycle
//  wb_stb_i    in   1        strobe
//  wb_dat_o    out  32       read data, valid while wb_ack_o=1
//  wb_ack_o    out  1        acknowledge
//  gpio_i      in   WIDTH    pad input (asynchronous)
//  gpio_o      out  WIDTH    pad output value
//  gpio_oe_o   out  WIDTH    pad output enable, 1 = drive
//  irq_o       out  1        level interrupt to CPU
// BEHAVIOUR
//  Register map (word offsets): 0x00 OUT rw, 0x04 DIR rw, 0x08 IN ro, 0x0C IRQ_MASK rw,
//   0x10 IRQ_STAT rw1c, 0x14 EDGE rw (1=rising, 0=falling). Bits above WIDTH read 0, writes ignored.
//  Reset: all registers 0, wb_ack_o=0, wb_dat_o=0, gpio_o=0, gpio_oe_o=0, irq_o=0, sync flops 0.
//  Handshake: wb_ack_o <= cyc & stb & ~wb_ack_o -> exactly one-cycle ack, one wait state;
//   back-to-back strobes are acked every other cycle. Writes commit on the ack cycle, only once.
//  Byte lanes: write updates bits [8n+7:8n] only if wb_sel_i[n]. Reads return the full word.
//  Unmapped offsets: read 0, write ignored, still acked (no bus hang).
//  gpio_o = OUT, gpio_oe_o = DIR, combinational from registers.
//  Input path: two-flop synchroniser, then one history flop; IN reads the second sync stage.
//   Latency pad->IN readable: 2 clocks. Edge detect compares sync2 vs history: rising=sync2&~hist,
//   falling=~sync2&hist, selected per bit by EDGE. Detection applies to all pins, incl. outputs.
//  IRQ_STAT[i] sets on selected edge; cleared by writing 1. Same-cycle set and clear: set wins.
//  irq_o registered: |(IRQ_STAT & IRQ_MASK), one cycle after the status/mask update.
//  Changing EDGE does not generate a spurious event; history flop keeps tracking.
//  Async reset mid-transfer: ack drops immediately; master must re-issue the cycle.
// CONFIGURATION
//  GPIO_IRQ_EN defined: IRQ_MASK, IRQ_STAT, EDGE, history flops and irq_o logic as above.
//  GPIO_IRQ_EN undefined: those registers are absent, offsets 0x0C-0x14 read 0/ignore writes
//   (still acked), irq_o tied 0; OUT/DIR/IN behaviour unchanged.
// TESTING
//  Reset then read all six offsets -> every read returns 0x00000000, each acked after exactly 1 wait.
//  Write DIR=0xFF, OUT=0xA5 with sel=4'b0001 -> gpio_oe_o=0xFF, gpio_o=0xA5; write sel=4'b0000 -> no change.
//  Drive gpio_i=0x3C -> IN reads 0x3C no earlier than 2 clocks after the change; unmapped 0x18 reads 0.
//  GPIO_IRQ_EN: EDGE=0x01, MASK=0x01, raise gpio_i[0] -> IRQ_STAT=0x01, irq_o=1; write 0x01 to 0x10 -> irq_o=0.
//  GPIO_IRQ_EN: falling edge on pin 3 in the same cycle as W1C of bit 3 -> IRQ_STAT[3] remains 1.
//  Build without GPIO_IRQ_EN: toggle all inputs -> irq_o stays 0, offset 0x10 reads 0.

Source files
------------

// File: rtl/wb_gpio_port_if.sv
// Wishbone classic bus bundle between the SoC interconnect (master) and wb_gpio_port (slave).
interface wb_gpio_port_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [31:0]           wb_dat_i;
    logic [3:0]            wb_sel_i;
    logic                  wb_we_i;
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_gpio_port.sv
// Wishbone classic GPIO controller: OUT/DIR/IN registers, synchronised inputs.
// Define GPIO_IRQ_EN to add IRQ_MASK, IRQ_STAT (W1C), EDGE and the registered irq_o.
module wb_gpio_port #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    wb_gpio_port_if.slave    wb,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);
    localparam logic [ADDR_WIDTH-3:0] IDX_OUT = (ADDR_WIDTH-2)'(0);
    localparam logic [ADDR_WIDTH-3:0] IDX_DIR = (ADDR_WIDTH-2)'(1);
    localparam logic [ADDR_WIDTH-3:0] IDX_IN  = (ADDR_WIDTH-2)'(2);

    logic                  r_ack;
    logic [31:0]           r_dat;
    logic [WIDTH-1:0]      r_out;
    logic [WIDTH-1:0]      r_dir;
    logic [WIDTH-1:0]      r_sync1;
    logic [WIDTH-1:0]      r_sync2;

    logic [ADDR_WIDTH-3:0] w_idx;
    logic                  w_xfer;
    logic                  w_wr;
    logic [31:0]           w_lane;
    logic [WIDTH-1:0]      w_wmask;
    logic [WIDTH-1:0]      w_wdat;
    logic [31:0]           w_rdata;
    logic                  w_unused_bits;

    // Handshake: a strobe is accepted when cyc&stb are high and ack is low; ack is then
    // high for exactly one cycle, so a held strobe is acked every other cycle. Writes commit
    // and read data is captured on the same edge that raises ack.
    assign w_idx   = wb.wb_adr_i[ADDR_WIDTH-1:2];
    assign w_xfer  = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_wr    = w_xfer & wb.wb_we_i;
    assign w_lane  = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                      {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    assign w_wmask = w_lane[WIDTH-1:0];
    assign w_wdat  = wb.wb_dat_i[WIDTH-1:0];

    assign w_unused_bits = ^{wb.wb_dat_i, wb.wb_adr_i[1:0], w_lane};

`ifdef GPIO_IRQ_EN
    localparam logic [ADDR_WIDTH-3:0] IDX_MASK = (ADDR_WIDTH-2)'(3);
    localparam logic [ADDR_WIDTH-3:0] IDX_STAT = (ADDR_WIDTH-2)'(4);
    localparam logic [ADDR_WIDTH-3:0] IDX_EDGE = (ADDR_WIDTH-2)'(5);

    logic [WIDTH-1:0] r_hist;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_stat;
    logic [WIDTH-1:0] r_edge;
    logic             r_irq;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] w_clr;

    // Events come only from sync2 vs history, so rewriting EDGE on a quiet pin sets nothing.
    assign w_evt = (r_edge & r_sync2 & ~r_hist) | (~r_edge & ~r_sync2 & r_hist);
    assign w_clr = (w_wr && (w_idx == IDX_STAT)) ? (w_wdat & w_wmask) : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_hist <= '0;
            r_mask <= '0;
            r_stat <= '0;
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_hist <= r_sync2;
            r_stat <= (r_stat & ~w_clr) | w_evt;
            r_irq  <= |(r_stat & r_mask);
            if (w_wr && (w_idx == IDX_MASK)) r_mask <= (r_mask & ~w_wmask) | (w_wdat & w_wmask);
            if (w_wr && (w_idx == IDX_EDGE)) r_edge <= (r_edge & ~w_wmask) | (w_wdat & w_wmask);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            IDX_OUT:  w_rdata = 32'(r_out);
            IDX_DIR:  w_rdata = 32'(r_dir);
            IDX_IN:   w_rdata = 32'(r_sync2);
`ifdef GPIO_IRQ_EN
            IDX_MASK: w_rdata = 32'(r_mask);
            IDX_STAT: w_rdata = 32'(r_stat);
            IDX_EDGE: w_rdata = 32'(r_edge);
`endif
            default:  w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ack   <= 1'b0;
            r_dat   <= 32'd0;
            r_out   <= '0;
            r_dir   <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_ack   <= wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
            r_dat   <= (w_xfer && !wb.wb_we_i) ? w_rdata : 32'd0;
            r_sync1 <= gpio_i;
            r_sync2 <= r_sync1;
            if (w_wr && (w_idx == IDX_OUT)) r_out <= (r_out & ~w_wmask) | (w_wdat & w_wmask);
            if (w_wr && (w_idx == IDX_DIR)) r_dir <= (r_dir & ~w_wmask) | (w_wdat & w_wmask);
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;
    assign gpio_o      = r_out;
    assign gpio_oe_o   = r_dir;
endmodule

// File: tb/tb_wb_gpio_port.sv
// Self-checking bench for wb_gpio_port: vector table, hand sequences and a random register model.
module tb_wb_gpio_port;
    localparam int WIDTH = 8;
    localparam int AW    = 5;
    localparam logic [31:0] PIN_MASK = 32'((64'd1 << WIDTH) - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_gpio_port_if #(.ADDR_WIDTH(AW)) bus ();
    logic [WIDTH-1:0] gpio_i;
    logic [WIDTH-1:0] gpio_o;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    wb_gpio_port #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb         (bus),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_oe_o  (gpio_oe),
        .irq_o      (irq)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic             we;
        logic [AW-1:0]    adr;
        logic [31:0]      dat;
        logic [3:0]       sel;
        logic [31:0]      exp_rd;
        logic [WIDTH-1:0] exp_o;
        logic [WIDTH-1:0] exp_oe;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output int waits);
        @(negedge clk);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        waits = 0;
        do begin
            @(posedge clk);
            #1;
            waits++;
        end while (!bus.wb_ack_o && waits < 8);
        rd = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input string name);
        logic [31:0] rd;
        int waits;
        wb_xfer(1'b1, adr, dat, sel, rd, waits);
        check({name, "_waits"}, waits, 1);
    endtask

    task automatic rd_chk(input logic [AW-1:0] adr, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        int waits;
        wb_xfer(1'b0, adr, 32'd0, 4'hF, rd, waits);
        check({name, "_waits"}, waits, 1);
        check(name, rd, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic [31:0] exp_rd,
                                input logic [WIDTH-1:0] exp_o, input logic [WIDTH-1:0] exp_oe);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
        v.exp_rd = exp_rd; v.exp_o = exp_o; v.exp_oe = exp_oe;
        return v;
    endfunction

    // Reference model: byte-lane merge of a write into a register, pins above WIDTH absent.
    function automatic logic [31:0] apply_lanes(input logic [31:0] old, input logic [31:0] dat,
                                                input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int n = 0; n < 4; n++)
            if (sel[n]) r[8*n +: 8] = dat[8*n +: 8];
        return r & PIN_MASK;
    endfunction

    logic [31:0] m_reg[8];
    logic [31:0] gpio_cur;

    function automatic bit model_writable(input int idx);
`ifdef GPIO_IRQ_EN
        return (idx == 0) || (idx == 1) || (idx == 3) || (idx == 5);
`else
        return (idx == 0) || (idx == 1);
`endif
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        if (idx == 2) return gpio_cur & PIN_MASK;
        if (model_writable(idx)) return m_reg[idx];
        return 32'd0;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int waits;

        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        gpio_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ack", bus.wb_ack_o, 0);
        check("rst_dat", bus.wb_dat_o, 0);
        check("rst_gpio_o", gpio_o, 0);
        check("rst_gpio_oe", gpio_oe, 0);
        check("rst_irq", irq, 0);

        vecs.push_back(mk(0, 5'h00, 0,            4'hF, 32'h0,  8'h00, 8'h00));
        vecs.push_back(mk(0, 5'h04, 0,            4'hF, 32'h0,  8'h00, 8'h00));
        vecs.push_back(mk(0, 5'h08, 0,            4'hF, 32'h0,  8'h00, 8'h00));
        vecs.push_back(mk(0, 5'h0C, 0,            4'hF, 32'h0,  8'h00, 8'h00));
        vecs.push_back(mk(0, 5'h10, 0,            4'hF, 32'h0,  8'h00, 8'h00));
        vecs.push_back(mk(0, 5'h14, 0,            4'hF, 32'h0,  8'h00, 8'h00));
        vecs.push_back(mk(1, 5'h04, 32'hFF,       4'h1, 32'h0,  8'h00, 8'hFF));
        vecs.push_back(mk(1, 5'h00, 32'hA5,       4'h1, 32'h0,  8'hA5, 8'hFF));
        vecs.push_back(mk(1, 5'h00, 32'h00,       4'h0, 32'h0,  8'hA5, 8'hFF));
        vecs.push_back(mk(0, 5'h00, 0,            4'hF, 32'hA5, 8'hA5, 8'hFF));
        vecs.push_back(mk(1, 5'h00, 32'hFFFFFF5A, 4'hE, 32'h0,  8'hA5, 8'hFF));
        vecs.push_back(mk(0, 5'h01, 0,            4'hF, 32'hA5, 8'hA5, 8'hFF));
        vecs.push_back(mk(1, 5'h18, 32'hFFFFFFFF, 4'hF, 32'h0,  8'hA5, 8'hFF));
        vecs.push_back(mk(0, 5'h18, 0,            4'hF, 32'h0,  8'hA5, 8'hFF));
        vecs.push_back(mk(1, 5'h08, 32'hFF,       4'hF, 32'h0,  8'hA5, 8'hFF));
        vecs.push_back(mk(0, 5'h08, 0,            4'hF, 32'h0,  8'hA5, 8'hFF));
        vecs.push_back(mk(1, 5'h04, 32'h00000F0F, 4'h3, 32'h0,  8'hA5, 8'h0F));
        vecs.push_back(mk(0, 5'h04, 0,            4'hF, 32'h0F, 8'hA5, 8'h0F));
        vecs.push_back(mk(1, 5'h00, 32'h3C,       4'h1, 32'h0,  8'h3C, 8'h0F));
        vecs.push_back(mk(0, 5'h1C, 0,            4'hF, 32'h0,  8'h3C, 8'h0F));

        foreach (vecs[i]) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, waits);
            check($sformatf("vec%0d_waits", i), waits, 1);
            if (!vecs[i].we) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_gpio_o", i), gpio_o, vecs[i].exp_o);
            check($sformatf("vec%0d_gpio_oe", i), gpio_oe, vecs[i].exp_oe);
        end

        // Held strobe: ack on every other edge, read data present with each ack.
        @(negedge clk);
        bus.wb_adr_i = 5'h00; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_ack%0d", k), bus.wb_ack_o, (k % 2 == 0) ? 1 : 0);
            if (bus.wb_ack_o) check($sformatf("b2b_dat%0d", k), bus.wb_dat_o, 32'h3C);
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(posedge clk);
        #1;

        // Pad change is not visible to a read captured only one edge later.
        @(negedge clk);
        gpio_i = 8'h3C;
        @(posedge clk);
        rd_chk(5'h08, 32'h0, "in_early");
        rd_chk(5'h08, 32'h3C, "in_late");

        m_reg = '{default: 32'd0};
        m_reg[0] = 32'h3C;
        m_reg[1] = 32'h0F;
        gpio_cur = 32'h3C;

        for (int it = 0; it < 60; it++) begin
            int idx;
            logic we;
            logic [31:0] dat;
            logic [3:0] sel;
            logic [AW-1:0] adr;
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                gpio_i = WIDTH'($urandom);
                gpio_cur = 32'(gpio_i);
                repeat (3) @(posedge clk);
            end
            idx = $urandom_range(0, 7);
`ifdef GPIO_IRQ_EN
            if (idx == 4) idx = 0;
`endif
            we  = 1'($urandom_range(0, 1));
            dat = $urandom;
            sel = 4'($urandom);
            adr = {3'(idx), 2'($urandom)};
            if (we) begin
                wb_xfer(1'b1, adr, dat, sel, rd, waits);
                check("rnd_wr_waits", waits, 1);
                if (model_writable(idx)) m_reg[idx] = apply_lanes(m_reg[idx], dat, sel);
            end else begin
                exp_q.push_back(model_read(idx));
                wb_xfer(1'b0, adr, 32'd0, sel, rd, waits);
                check("rnd_rd_waits", waits, 1);
                check($sformatf("rnd_rd_idx%0d", idx), rd, exp_q.pop_front());
            end
            check("rnd_gpio_o", gpio_o, m_reg[0]);
            check("rnd_gpio_oe", gpio_oe, m_reg[1]);
`ifndef GPIO_IRQ_EN
            check("rnd_irq", irq, 0);
`endif
        end

        // Reset asserted while ack is high: ack and all state drop at once.
        @(negedge clk);
        gpio_i = '0;
        bus.wb_adr_i = 5'h00; bus.wb_we_i = 1'b0;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk);
        #1;
        check("mid_ack_before", bus.wb_ack_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_ack_after", bus.wb_ack_o, 0);
        check("mid_dat_after", bus.wb_dat_o, 0);
        check("mid_gpio_o", gpio_o, 0);
        check("mid_gpio_oe", gpio_oe, 0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        rd_chk(5'h00, 32'h0, "post_rst_out");

`ifdef GPIO_IRQ_EN
        wr(5'h14, 32'h01, 4'h1, "irq_edge_wr");
        wr(5'h0C, 32'h01, 4'h1, "irq_mask_wr");
        rd_chk(5'h10, 32'h0, "irq_stat_idle");
        check("irq_idle", irq, 0);
        @(negedge clk);
        gpio_i = 8'h01;
        repeat (4) @(posedge clk);
        #1;
        check("irq_rise", irq, 1);
        rd_chk(5'h10, 32'h01, "irq_stat_rise");
        wr(5'h10, 32'h01, 4'h1, "irq_w1c");
        check("irq_cleared", irq, 0);
        rd_chk(5'h10, 32'h0, "irq_stat_cleared");
        @(negedge clk);
        gpio_i = 8'h09;
        repeat (4) @(posedge clk);
        rd_chk(5'h10, 32'h0, "irq_rise_unselected");
        // Falling edge on pin 3 lands on the same edge as the W1C of bit 3.
        @(negedge clk);
        gpio_i = 8'h01;
        @(posedge clk);
        @(posedge clk);
        wr(5'h10, 32'h08, 4'h1, "irq_w1c_race");
        rd_chk(5'h10, 32'h08, "irq_set_wins");
        check("irq_masked_off", irq, 0);
        wr(5'h14, 32'hFF, 4'h1, "irq_edge_ff");
        wr(5'h14, 32'h00, 4'h1, "irq_edge_00");
        rd_chk(5'h10, 32'h08, "irq_no_spurious");
        wr(5'h0C, 32'h08, 4'h1, "irq_mask8");
        check("irq_mask_on", irq, 1);
        wr(5'h10, 32'h08, 4'h1, "irq_w1c8");
        check("irq_final", irq, 0);
        rd_chk(5'h10, 32'h0, "irq_stat_final");
`else
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            gpio_i = (t % 2 == 0) ? 8'hFF : 8'h00;
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("noirq_toggle%0d", t), irq, 0);
        end
        rd_chk(5'h10, 32'h0, "noirq_stat");
        wr(5'h0C, 32'hFF, 4'hF, "noirq_mask_wr");
        rd_chk(5'h0C, 32'h0, "noirq_mask_rd");
        check("noirq_final", irq, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
